// File: rtl/axis_uart_bridge_tx_pkg.sv
// Shared definitions for the AXI-Stream/UART bridge (transmit and receive halves).
package axis_uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE_ST  = 2'd0,
    START_ST = 2'd1,
    DATA_ST  = 2'd2,
    STOP_ST  = 2'd3
  } tx_fsm;

  localparam int UART_DATA_BITS = 8;

  // Clock cycles per UART bit; integer division truncates so both halves agree.
  function automatic int clock_duration(input int freq_hz, input int uart_speed);
    return freq_hz / uart_speed;
  endfunction

endpackage

// File: rtl/axis_uart_bridge_tx_if.sv
// AXI-Stream word channel feeding the UART transmitter.
interface axis_uart_bridge_tx_if #(
  parameter int N_BYTES = 32
);
  logic [N_BYTES*8-1:0] S_AXIS_TDATA;
  logic                 S_AXIS_TVALID;
  logic                 S_AXIS_TREADY;

  modport master (
    output S_AXIS_TDATA,
    output S_AXIS_TVALID,
    input  S_AXIS_TREADY
  );

  modport slave (
    input  S_AXIS_TDATA,
    input  S_AXIS_TVALID,
    output S_AXIS_TREADY
  );
endinterface

// File: rtl/axis_uart_bridge_tx_bit_timer.sv
// Bit-period timer: counts 0..CLK_DUR-1 while enabled, pulses bit_end_o on the last count.
module uart_tx_bit_timer #(
  parameter int CLK_DUR = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o
);
  localparam int CW = (CLK_DUR > 1) ? $clog2(CLK_DUR) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DUR - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = en_i & (cnt_q == LAST);

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Clear on a new word, otherwise wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)             cnt_d = '0;
    else if (en_i)         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end
endmodule

// File: rtl/axis_uart_bridge_tx.sv
// AXI-Stream to UART transmitter: each accepted word leaves as N_BYTES 8N1 frames,
// byte 0 first, each byte LSB-first.
module axis_uart_bridge_tx
  import axis_uart_bridge_pkg::*;
#(
  parameter int UART_SPEED = 115200,
  parameter int FREQ_HZ    = 100000000,
  parameter int N_BYTES    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  axis_uart_bridge_tx_if.slave  s_axis,
  output logic                  UART_TX,
  output logic                  BUSY
);
  localparam int CLK_DUR = clock_duration(FREQ_HZ, UART_SPEED);
  localparam int BW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(N_BYTES - 1);

  tx_fsm                state_q, state_d;
  logic [N_BYTES*8-1:0] word_q, word_d;
  logic [BW-1:0]        byte_q, byte_d;
  logic [2:0]           bit_q, bit_d;
  logic                 tx_q, tx_d;
  logic                 tready_q, tready_d;
  logic                 busy_q, busy_d;
  logic                 bit_end;
  logic                 hs;
  logic [7:0]           cur_byte;

  assign hs                   = s_axis.S_AXIS_TVALID & tready_q;
  assign s_axis.S_AXIS_TREADY = tready_q;
  assign UART_TX              = tx_q;
  assign BUSY                 = busy_q;
  assign cur_byte             = 8'(word_q >> {byte_q, 3'b000});

  uart_tx_bit_timer #(.CLK_DUR(CLK_DUR)) u_timer (
    .clk       (clk),
    .rst       (reset),
    .en_i      (state_q != IDLE_ST),
    .clr_i     (hs),
    .bit_end_o (bit_end)
  );

  // State, indices and registered outputs; reset forces the line high at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE_ST;
      byte_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
    end
  end

  // Held word; only read while a transfer is in progress, so it needs no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  // Next-state logic: frame sequencing across bits and bytes.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE_ST: begin
        if (hs) begin
          word_d  = s_axis.S_AXIS_TDATA;
          byte_d  = '0;
          bit_d   = '0;
          state_d = START_ST;
        end
      end
      START_ST: begin
        if (bit_end) state_d = DATA_ST;
      end
      DATA_ST: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP_ST;
        end
      end
      STOP_ST: begin
        if (bit_end) begin
          if (byte_q < LAST_BYTE) begin
            byte_d  = byte_q + BW'(1);
            state_d = START_ST;
          end else begin
            state_d = IDLE_ST;
          end
        end
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // Output logic: computed from the next state so every output comes straight from a flop.
  always_comb begin
    tready_d = (state_d == IDLE_ST);
    busy_d   = (state_d != IDLE_ST);
    case (state_d)
      START_ST: tx_d = 1'b0;
      DATA_ST:  tx_d = cur_byte[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_axis_uart_bridge_tx.sv
// Bench for axis_uart_bridge_tx: two instances (fast and 115200 baud) checked cycle by
// cycle against a frame-timeline model derived from the 8N1 line format.
module tb_axis_uart_bridge_tx;
  localparam int CD_A  = 100000000 / 10000000;
  localparam int NB_A  = 2;
  localparam int LEN_A = NB_A * 10 * CD_A;
  localparam int CD_B  = 100000000 / 115200;
  localparam int NB_B  = 2;
  localparam int LEN_B = NB_B * 10 * CD_B;
  localparam int WAIT_MAX = 40000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tx_a, busy_a, tx_b, busy_b;

  axis_uart_bridge_tx_if #(.N_BYTES(NB_A)) axa ();
  axis_uart_bridge_tx_if #(.N_BYTES(NB_B)) axb ();

  axis_uart_bridge_tx #(.UART_SPEED(10000000), .FREQ_HZ(100000000), .N_BYTES(NB_A)) dut_a (
    .clk(clk), .reset(reset), .s_axis(axa), .UART_TX(tx_a), .BUSY(busy_a));

  axis_uart_bridge_tx #(.UART_SPEED(115200), .FREQ_HZ(100000000), .N_BYTES(NB_B)) dut_b (
    .clk(clk), .reset(reset), .s_axis(axb), .UART_TX(tx_b), .BUSY(busy_b));

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Line level k cycles after a handshake (k=1 is the first start-bit cycle).
  function automatic logic exp_line(input logic [15:0] w, input int k, input int cd);
    int bp, b;
    bp = (k - 1) / cd;
    b  = bp % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return w[(bp / 10) * 8 + b - 1];
  endfunction

  // Reference timeline for instance A.
  int a_k = 0, a_rel = 0, cyc = 0, a_hs_cyc = 0, a_prev_hs = 0;
  bit a_act = 1'b0;
  logic [15:0] a_word = '0;
  always @(negedge clk) begin : mon_a
    bit rdy;
    cyc++;
    if (reset) begin
      a_act = 1'b0; a_k = 0; a_rel = 0;
      check_eq("a_rst_tx", 32'(tx_a), 32'd1);
      check_eq("a_rst_tready", 32'(axa.S_AXIS_TREADY), 32'd0);
      check_eq("a_rst_busy", 32'(busy_a), 32'd0);
    end else begin
      if (a_rel < 2) a_rel++;
      if (a_act) begin
        a_k++;
        if (a_k > LEN_A) a_act = 1'b0;
      end
      rdy = !a_act && (a_rel >= 2);
      check_eq("a_tx", 32'(tx_a), 32'(a_act ? exp_line(a_word, a_k, CD_A) : 1'b1));
      check_eq("a_busy", 32'(busy_a), 32'(a_act));
      check_eq("a_tready", 32'(axa.S_AXIS_TREADY), 32'(rdy));
      if (axa.S_AXIS_TVALID && rdy) begin
        a_act = 1'b1; a_k = 0; a_word = axa.S_AXIS_TDATA;
        a_prev_hs = a_hs_cyc; a_hs_cyc = cyc;
      end
    end
  end

  // Reference timeline for instance B.
  int b_k = 0, b_rel = 0;
  bit b_act = 1'b0;
  logic [15:0] b_word = '0;
  always @(negedge clk) begin : mon_b
    bit rdy;
    if (reset) begin
      b_act = 1'b0; b_k = 0; b_rel = 0;
      check_eq("b_rst_tx", 32'(tx_b), 32'd1);
      check_eq("b_rst_tready", 32'(axb.S_AXIS_TREADY), 32'd0);
    end else begin
      if (b_rel < 2) b_rel++;
      if (b_act) begin
        b_k++;
        if (b_k > LEN_B) b_act = 1'b0;
      end
      rdy = !b_act && (b_rel >= 2);
      check_eq("b_tx", 32'(tx_b), 32'(b_act ? exp_line(b_word, b_k, CD_B) : 1'b1));
      check_eq("b_busy", 32'(busy_b), 32'(b_act));
      check_eq("b_tready", 32'(axb.S_AXIS_TREADY), 32'(rdy));
      if (axb.S_AXIS_TVALID && rdy) begin
        b_act = 1'b1; b_k = 0; b_word = axb.S_AXIS_TDATA;
      end
    end
  end

  function automatic logic rdy_of(input int which);
    return (which == 0) ? axa.S_AXIS_TREADY : axb.S_AXIS_TREADY;
  endfunction

  // Present a word, wait for acceptance; returns one #1 after the handshake edge.
  task automatic send(input int which, input logic [15:0] w, input bit hold);
    int n = 0;
    if (which == 0) begin axa.S_AXIS_TDATA = w; axa.S_AXIS_TVALID = 1'b1; end
    else            begin axb.S_AXIS_TDATA = w; axb.S_AXIS_TVALID = 1'b1; end
    while (!rdy_of(which) && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
    check_eq("hs_wait", 32'(n < WAIT_MAX), 32'd1);
    @(posedge clk); #1;
    if (!hold) begin
      if (which == 0) axa.S_AXIS_TVALID = 1'b0;
      else            axb.S_AXIS_TVALID = 1'b0;
    end
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    while (!rdy_of(which) && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
    check_eq("idle_wait", 32'(n < WAIT_MAX), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    axa.S_AXIS_TVALID = 1'b0; axa.S_AXIS_TDATA = '0;
    axb.S_AXIS_TVALID = 1'b0; axb.S_AXIS_TDATA = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single word: frames 0x5A then 0xA5; TREADY back in cycle T+201.
    send(0, 16'hA55A, 1'b0);
    n = 0;
    while (!axa.S_AXIS_TREADY && n < 1000) begin @(posedge clk); #1; n++; end
    check_eq("a_rdy_latency", 32'(n + 1), 32'(LEN_A + 1));

    // Back-to-back with TVALID held high.
    send(0, 16'h0001, 1'b1);
    send(0, 16'hFFFF, 1'b0);
    check_eq("a_b2b_gap", 32'(a_hs_cyc - a_prev_hs), 32'(LEN_A + 1));
    wait_idle(0);

    // Random words with TVALID/TDATA churning while busy.
    for (int i = 0; i < 25; i++) begin
      send(0, 16'($urandom), 1'b0);
      repeat ($urandom_range(0, 240)) begin
        axa.S_AXIS_TVALID = 1'($urandom);
        axa.S_AXIS_TDATA  = 16'($urandom);
        @(posedge clk); #1;
      end
      axa.S_AXIS_TVALID = 1'b0;
    end
    wait_idle(0);

    // Reset in the third data bit of byte 1 (0xC3 bit 2 is 0).
    send(0, 16'hC3A7, 1'b0);
    repeat (13 * CD_A + 5) @(posedge clk);
    #1;
    check_eq("a_pre_rst_tx", 32'(tx_a), 32'(exp_line(16'hC3A7, 13 * CD_A + 6, CD_A)));
    reset = 1'b1;
    #1;
    check_eq("a_rst_async_tx", 32'(tx_a), 32'd1);
    check_eq("a_rst_async_busy", 32'(busy_a), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("a_rel_rdy1", 32'(axa.S_AXIS_TREADY), 32'd0);
    @(posedge clk); #1;
    check_eq("a_rel_rdy2", 32'(axa.S_AXIS_TREADY), 32'd1);
    send(0, 16'h1234, 1'b0);
    wait_idle(0);

    // 115200 baud: start bit of byte 0x01 is followed by a 1, so its low run is one bit period.
    send(1, 16'h5A01, 1'b0);
    n = 0;
    while (tx_b === 1'b0 && n < 2000) begin n++; @(posedge clk); #1; end
    check_eq("b_bit_period", 32'(n), 32'(CD_B));
    wait_idle(1);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
